// File: rtl/sdrxframe_if.sv
// ---------------------------------------------------------------------------
// sdrxframe_if
//   Bus bundle between an SDIO data-block receiver and its host logic.
//   The host (master) drives the arming/configuration and the pre-sampled
//   DAT pins with their strobe. The receiver (slave) returns the word stream
//   and the end-of-block status.
//
//   Configuration / sample side (master -> slave):
//     i_en       arm receiver
//     i_width    bus width: 00 = 1 lane, 01 = 4 lanes, 1x = 8 lanes
//     i_ddr      DDR mode (two samples per SD clock)
//     i_len      block length in bytes (LGLEN+1 bits)
//     i_stb      a new pin sample is valid this cycle
//     i_dat      sampled DAT[7:0]
//   Result side (slave -> master):
//     o_valid    one-cycle pulse, o_data holds a received word
//     o_data     received word, first bit received at bit 31
//     o_last     high with the final word's o_valid
//     o_done     one-cycle pulse, block finished
//     o_crcerr   with o_done: some used CRC remainder nonzero
//     o_enderr   with o_done: end bit not 1 on every active lane
//     o_timeout  with o_done: start-bit wait expired
//     o_busy     receiver is not idle
// ---------------------------------------------------------------------------
interface sdrxframe_if #(
  parameter int LGLEN = 9
);
  logic             i_en;
  logic [1:0]       i_width;
  logic             i_ddr;
  logic [LGLEN:0]   i_len;
  logic             i_stb;
  logic [7:0]       i_dat;

  logic             o_valid;
  logic [31:0]      o_data;
  logic             o_last;
  logic             o_done;
  logic             o_crcerr;
  logic             o_enderr;
  logic             o_timeout;
  logic             o_busy;

  modport master (
    output i_en, i_width, i_ddr, i_len, i_stb, i_dat,
    input  o_valid, o_data, o_last, o_done, o_crcerr, o_enderr, o_timeout, o_busy
  );

  modport slave (
    input  i_en, i_width, i_ddr, i_len, i_stb, i_dat,
    output o_valid, o_data, o_last, o_done, o_crcerr, o_enderr, o_timeout, o_busy
  );
endinterface

// File: rtl/sdrxframe.sv
// ---------------------------------------------------------------------------
// sdrxframe
//   Host-side SDIO data-block receiver. Waits for the start bit on the active
//   DAT lanes, packs payload bits MSB-first into 32-bit words, then consumes
//   the per-lane CRC16 field and the end bit and reports block status.
//   Runs on the system clock; the front end supplies one i_stb per sample
//   (one per SD clock in SDR, two in DDR).
//
//   Parameters:
//     LGLEN      log2 of the largest block length in bytes (i_len is LGLEN+1 bits)
//     LGTIMEOUT  width of the start-bit timeout counter (i_clk cycles)
//
//   Ports:
//     i_clk      system clock
//     i_reset    synchronous, active-high reset
//     bus        sdrxframe_if.slave: i_en/i_width/i_ddr/i_len/i_stb/i_dat in,
//                o_valid/o_data/o_last/o_done/o_crcerr/o_enderr/o_timeout/o_busy out
//
//   Build option:
//     SDRXFRAME_CRC_EN  when defined, per-lane/per-bank CRC16 registers are
//                       built and checked. When undefined the CRC field is
//                       still counted and consumed with identical timing, but
//                       o_crcerr is always 0.
// ---------------------------------------------------------------------------
module sdrxframe #(
  parameter int LGLEN     = 9,
  parameter int LGTIMEOUT = 23
) (
  input  logic       i_clk,
  input  logic       i_reset,
  sdrxframe_if.slave bus
);

  localparam int LEN_W = LGLEN + 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_DATA       = 3'd2,
    S_CRC        = 3'd3,
    S_ENDBIT     = 3'd4
  } state_t;

  // Sequencer state and block configuration (latched when leaving IDLE)
  state_t               state_r;
  logic [1:0]           width_r;
  logic                 ddr_r;
  logic [LEN_W-1:0]     len_r;

  // Counters
  logic [LGTIMEOUT-1:0] tcnt_r;
  logic [4:0]           bit_cnt_r;
  logic [LEN_W-1:0]     byte_cnt_r;
  logic [5:0]           crc_cnt_r;

  // DDR phase and the "discard sample after start bit" flag
  logic                 phase_r;
  logic                 skip_r;

  logic [31:0]          word_r;

  // Registered outputs
  logic                 valid_r;
  logic [31:0]          data_r;
  logic                 last_r;
  logic                 done_r;
  logic                 crcerr_r;
  logic                 enderr_r;
  logic                 timeout_r;
  logic                 busy_r;

  // Combinational helpers
  logic [7:0]           lane_mask_s;
  logic [5:0]           nbits_s;
  logic [31:0]          word_s;
  logic [5:0]           bit_sum_s;
  logic                 word_done_s;
  logic [LEN_W-1:0]     byte_next_s;
  logic                 last_word_s;
  logic [5:0]           crc_cnt_next_s;
  logic                 crc_fin_s;
  logic [LGTIMEOUT-1:0] tcnt_next_s;
  logic                 tmo_s;
  logic                 start_s;
  logic                 end_ok_s;
  logic                 crc_bad_s;

  // Decode lane mask / bits-per-sample and build the next packed word
  always_comb begin
    lane_mask_s = 8'h01;
    nbits_s     = 6'd1;
    word_s      = {word_r[30:0], bus.i_dat[0]};
    case (width_r)
      2'b00: begin
        lane_mask_s = 8'h01;
        nbits_s     = 6'd1;
        word_s      = {word_r[30:0], bus.i_dat[0]};
      end
      2'b01: begin
        lane_mask_s = 8'h0F;
        nbits_s     = 6'd4;
        word_s      = {word_r[27:0], bus.i_dat[3:0]};
      end
      default: begin
        lane_mask_s = 8'hFF;
        nbits_s     = 6'd8;
        word_s      = {word_r[23:0], bus.i_dat[7:0]};
      end
    endcase
  end

  // Word, byte, CRC-field and timeout progress
  always_comb begin
    // bit_cnt_r only ever holds multiples of B, so the sum hits exactly 32
    bit_sum_s      = {1'b0, bit_cnt_r} + nbits_s;
    word_done_s    = bit_sum_s[5];
    byte_next_s    = byte_cnt_r + LEN_W'(4);
    last_word_s    = (byte_next_s == len_r);
    crc_cnt_next_s = crc_cnt_r + 6'd1;
    if (ddr_r) begin
      crc_fin_s = (crc_cnt_next_s == 6'd32);
    end else begin
      crc_fin_s = (crc_cnt_next_s == 6'd16);
    end
    tcnt_next_s    = tcnt_r + LGTIMEOUT'(1);
    tmo_s          = &tcnt_next_s;
    start_s        = ((bus.i_dat & lane_mask_s) == 8'h00);
    end_ok_s       = ((bus.i_dat & lane_mask_s) == lane_mask_s);
  end

`ifdef SDRXFRAME_CRC_EN
  // One CRC16 step, polynomial 0x1021, MSB first
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Bank 0 takes SDR samples and DDR phase-0 samples; bank 1 takes DDR phase-1 samples
  logic [7:0][15:0] crc0_r;
  logic [7:0][15:0] crc1_r;
  logic             crc_clear_s;
  logic             crc_step_s;
  logic             bank_s;

  // Decide when the CRC banks clear or advance
  always_comb begin
    crc_clear_s = (state_r == S_IDLE) && bus.i_en;
    bank_s      = ddr_r & phase_r;
    if (bus.i_stb) begin
      crc_step_s = ((state_r == S_DATA) && !skip_r) || (state_r == S_CRC);
    end else begin
      crc_step_s = 1'b0;
    end
    // Inactive lanes are never stepped, so their registers stay 0
    crc_bad_s = (|crc0_r) | (|crc1_r);
  end

  // Per-lane CRC16 registers
  always_ff @(posedge i_clk) begin
    if (i_reset || crc_clear_s) begin
      crc0_r <= {8{16'h0000}};
      crc1_r <= {8{16'h0000}};
    end else if (crc_step_s) begin
      for (int l = 0; l < 8; l++) begin
        if (lane_mask_s[l]) begin
          if (bank_s) begin
            crc1_r[l] <= crc16_step(crc1_r[l], bus.i_dat[l]);
          end else begin
            crc0_r[l] <= crc16_step(crc0_r[l], bus.i_dat[l]);
          end
        end
      end
    end
  end
`else
  assign crc_bad_s = 1'b0;
`endif

  // Block sequencer: start detection, word packing, CRC/end-bit counting, status pulses
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r    <= S_IDLE;
      width_r    <= 2'b00;
      ddr_r      <= 1'b0;
      len_r      <= {LEN_W{1'b0}};
      tcnt_r     <= {LGTIMEOUT{1'b0}};
      bit_cnt_r  <= 5'd0;
      byte_cnt_r <= {LEN_W{1'b0}};
      crc_cnt_r  <= 6'd0;
      phase_r    <= 1'b0;
      skip_r     <= 1'b0;
      word_r     <= 32'h0000_0000;
      valid_r    <= 1'b0;
      data_r     <= 32'h0000_0000;
      last_r     <= 1'b0;
      done_r     <= 1'b0;
      crcerr_r   <= 1'b0;
      enderr_r   <= 1'b0;
      timeout_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      // Pulse outputs default low; o_data keeps the last word
      valid_r   <= 1'b0;
      last_r    <= 1'b0;
      done_r    <= 1'b0;
      crcerr_r  <= 1'b0;
      enderr_r  <= 1'b0;
      timeout_r <= 1'b0;

      if ((state_r != S_IDLE) && !bus.i_en) begin
        // Disarm aborts silently: no o_done, nothing more emitted
        state_r <= S_IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (bus.i_en) begin
              width_r    <= bus.i_width;
              ddr_r      <= bus.i_ddr;
              len_r      <= bus.i_len;
              tcnt_r     <= {LGTIMEOUT{1'b0}};
              bit_cnt_r  <= 5'd0;
              byte_cnt_r <= {LEN_W{1'b0}};
              crc_cnt_r  <= 6'd0;
              phase_r    <= 1'b0;
              skip_r     <= 1'b0;
              state_r    <= S_WAIT_START;
              busy_r     <= 1'b1;
            end else begin
              busy_r     <= 1'b0;
            end
          end

          S_WAIT_START: begin
            if (bus.i_stb && start_s) begin
              // In DDR the start bit spans a whole clock; drop its second half
              skip_r  <= ddr_r;
              state_r <= S_DATA;
            end else if (tmo_s) begin
              done_r    <= 1'b1;
              timeout_r <= 1'b1;
              state_r   <= S_IDLE;
              busy_r    <= 1'b0;
            end else begin
              tcnt_r    <= tcnt_next_s;
            end
          end

          S_DATA: begin
            if (bus.i_stb) begin
              if (skip_r) begin
                skip_r <= 1'b0;
              end else begin
                word_r    <= word_s;
                phase_r   <= ~phase_r;
                bit_cnt_r <= bit_sum_s[4:0];
                if (word_done_s) begin
                  valid_r    <= 1'b1;
                  data_r     <= word_s;
                  last_r     <= last_word_s;
                  byte_cnt_r <= byte_next_s;
                  if (last_word_s) begin
                    state_r <= S_CRC;
                  end else begin
                    state_r <= S_DATA;
                  end
                end
              end
            end
          end

          S_CRC: begin
            if (bus.i_stb) begin
              phase_r   <= ~phase_r;
              crc_cnt_r <= crc_cnt_next_s;
              if (crc_fin_s) begin
                state_r <= S_ENDBIT;
              end else begin
                state_r <= S_CRC;
              end
            end
          end

          S_ENDBIT: begin
            if (bus.i_stb) begin
              done_r   <= 1'b1;
              enderr_r <= ~end_ok_s;
              crcerr_r <= crc_bad_s;
              state_r  <= S_IDLE;
              busy_r   <= 1'b0;
            end
          end

          default: begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_valid   = valid_r;
  assign bus.o_data    = data_r;
  assign bus.o_last    = last_r;
  assign bus.o_done    = done_r;
  assign bus.o_crcerr  = crcerr_r;
  assign bus.o_enderr  = enderr_r;
  assign bus.o_timeout = timeout_r;
  assign bus.o_busy    = busy_r;

endmodule
